// File: rtl/regfile_wb_ctrl_if.sv
// Write-request handshake between a result producer and the register-file
// write-back sequencer.
interface regfile_wb_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_addr;
  logic [7:0] in_data;

  modport master (output in_valid, output in_addr, output in_data, input in_ready);
  modport slave  (input in_valid, input in_addr, input in_data, output in_ready);
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Write-back sequencer for a 4x8 dual-port register file: queues write requests,
// generates a glitch-free asynchronous write strobe and forwards pending writes.
module regfile_wb_ctrl #(
  parameter int DEPTH         = 2,
  parameter int STROBE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        _reset,
  regfile_wb_ctrl_if.slave in_if,
  output logic        _wr_en,
  output logic [1:0]  wr_addr,
  output logic [7:0]  wr_data,
  input  logic        _rdL_en,
  input  logic [1:0]  rdL_addr,
  input  logic [7:0]  rdL_raw,
  output logic [7:0]  rdL_fwd,
  input  logic        _rdR_en,
  input  logic [1:0]  rdR_addr,
  input  logic [7:0]  rdR_raw,
  output logic [7:0]  rdR_fwd,
  output logic        busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [1:0] SC_LAST = 2'(STROBE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t        state_q;
  logic          wr_en_n_q;
  logic [1:0]    strobe_cnt_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    q_addr_q [DEPTH];
  logic [1:0]    q_addr_d [DEPTH];
  logic [7:0]    q_data_q [DEPTH];
  logic [7:0]    q_data_d [DEPTH];
  logic [1:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          push_s, pop_s;
  logic [CW-1:0] push_idx_s;

  // Head is popped at the end of HOLD; the queue is never empty in that state.
  assign pop_s           = (state_q == HOLD);
  assign in_if.in_ready  = (cnt_q < CW'(DEPTH));
  assign push_s          = in_if.in_valid && in_if.in_ready;
  assign push_idx_s      = pop_s ? (cnt_q - CW'(1)) : cnt_q;

  // Queue next-state: shift toward the head on pop, append at the tail on push.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < DEPTH; i++) begin
      q_addr_d[i] = q_addr_q[i];
      q_data_d[i] = q_data_q[i];
    end
    if (pop_s) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        q_addr_d[i] = q_addr_q[i+1];
        q_data_d[i] = q_data_q[i+1];
      end
    end else begin
      cnt_d = cnt_q;
    end
    if (push_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == push_idx_s) begin
          q_addr_d[i] = in_if.in_addr;
          q_data_d[i] = in_if.in_data;
        end else begin
          q_addr_d[i] = q_addr_d[i];
        end
      end
    end else begin
      cnt_d = cnt_d;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Queue storage and occupancy.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_addr_q[i] <= 2'd0;
        q_data_q[i] <= 8'd0;
      end
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        q_addr_q[i] <= q_addr_d[i];
        q_data_q[i] <= q_data_d[i];
      end
    end
  end

  // Write strobe sequencer; _wr_en comes straight from a flop.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q      <= IDLE;
      wr_en_n_q    <= 1'b1;
      strobe_cnt_q <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          wr_en_n_q <= 1'b1;
          if (cnt_q != '0) state_q <= SETUP;
          else             state_q <= IDLE;
        end
        SETUP: begin
          wr_en_n_q    <= 1'b0;
          strobe_cnt_q <= 2'd0;
          state_q      <= STROBE;
        end
        STROBE: begin
          if (strobe_cnt_q == SC_LAST) begin
            wr_en_n_q <= 1'b1;
            state_q   <= HOLD;
          end else begin
            strobe_cnt_q <= strobe_cnt_q + 2'd1;
          end
        end
        HOLD: begin
          wr_en_n_q <= 1'b1;
          if (cnt_q > CW'(1)) state_q <= SETUP;
          else                state_q <= IDLE;
        end
        default: begin
          wr_en_n_q <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  // Address/data load: IDLE takes the head, HOLD takes the entry behind it.
  always_comb begin
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (state_q == IDLE && cnt_q != '0) begin
      wr_addr_d = q_addr_q[0];
      wr_data_d = q_data_q[0];
    end else if (state_q == HOLD && cnt_q > CW'(1)) begin
      wr_addr_d = q_addr_q[1];
      wr_data_d = q_data_q[1];
    end else begin
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
    end
  end

  // Deliberately unreset so a reset during STROBE still latches the right data.
  always_ff @(posedge clk) begin
    wr_addr_q <= wr_addr_d;
    wr_data_q <= wr_data_d;
  end

  // Forwarding: later (younger) matches overwrite earlier ones.
  always_comb begin
    rdL_fwd = rdL_raw;
    rdR_fwd = rdR_raw;
    for (int i = 0; i < DEPTH; i++) begin
      if (!_rdL_en && CW'(i) < cnt_q && q_addr_q[i] == rdL_addr) rdL_fwd = q_data_q[i];
      else                                                      rdL_fwd = rdL_fwd;
      if (!_rdR_en && CW'(i) < cnt_q && q_addr_q[i] == rdR_addr) rdR_fwd = q_data_q[i];
      else                                                      rdR_fwd = rdR_fwd;
    end
  end

  assign _wr_en  = wr_en_n_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = (cnt_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl with a behavioural 4x8 register file model.
module tb_regfile_wb_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_ctrl_if a_if ();
  regfile_wb_ctrl_if b_if ();

  logic       a_wr_en_n, b_wr_en_n;
  logic [1:0] a_wr_addr, b_wr_addr;
  logic [7:0] a_wr_data, b_wr_data;
  logic       a_busy, b_busy;
  logic       rdl_en_n = 1'b1, rdr_en_n = 1'b1;
  logic [1:0] rdl_addr = 2'd0, rdr_addr = 2'd0;
  logic [7:0] rdl_raw, rdr_raw, rdl_fwd, rdr_fwd;
  logic [7:0] b_rdl_fwd, b_rdr_fwd;
  logic [7:0] rf [4];

  int n_vec = 0, n_err = 0;
  int rises = 0, b_rises = 0, log_n = 0;
  logic [1:0] log_addr [16];
  logic armed = 1'b0;

  assign rdl_raw = rf[rdl_addr];
  assign rdr_raw = rf[rdr_addr];

  regfile_wb_ctrl #(.DEPTH(2), .STROBE_CYCLES(1)) dut_a (
    .clk(clk), ._reset(rst_n), .in_if(a_if.slave),
    ._wr_en(a_wr_en_n), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    ._rdL_en(rdl_en_n), .rdL_addr(rdl_addr), .rdL_raw(rdl_raw), .rdL_fwd(rdl_fwd),
    ._rdR_en(rdr_en_n), .rdR_addr(rdr_addr), .rdR_raw(rdr_raw), .rdR_fwd(rdr_fwd),
    .busy(a_busy)
  );

  regfile_wb_ctrl #(.DEPTH(2), .STROBE_CYCLES(3)) dut_b (
    .clk(clk), ._reset(rst_n), .in_if(b_if.slave),
    ._wr_en(b_wr_en_n), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    ._rdL_en(1'b1), .rdL_addr(2'd0), .rdL_raw(8'd0), .rdL_fwd(b_rdl_fwd),
    ._rdR_en(1'b1), .rdR_addr(2'd0), .rdR_raw(8'd0), .rdR_fwd(b_rdr_fwd),
    .busy(b_busy)
  );

  // Register file latches on the rising edge of the active-low strobe.
  always @(posedge a_wr_en_n) begin
    if (armed) begin
      rf[a_wr_addr] <= a_wr_data;
      log_addr[log_n[3:0]] <= a_wr_addr;
      log_n <= log_n + 1;
      rises <= rises + 1;
    end
  end

  always @(posedge b_wr_en_n) begin
    if (armed) b_rises <= b_rises + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [1:0] a, input logic [7:0] d, output int waited);
    logic acc;
    acc = 1'b0;
    waited = 0;
    a_if.in_valid = 1'b1;
    a_if.in_addr  = a;
    a_if.in_data  = d;
    for (int k = 0; k < 50; k++) begin
      acc = a_if.in_ready;
      step();
      waited++;
      if (acc) break;
    end
    if (!acc) check("push_timeout", 32'd0, 32'd1);
    a_if.in_valid = 1'b0;
  endtask

  task automatic drain_a();
    for (int k = 0; k < 100; k++) begin
      if (!a_busy) break;
      step();
    end
    check("drain_timeout", {31'd0, a_busy}, 32'd0);
  endtask

  initial begin
    int w, base, lows;
    a_if.in_valid = 1'b0; a_if.in_addr = 2'd0; a_if.in_data = 8'd0;
    b_if.in_valid = 1'b0; b_if.in_addr = 2'd0; b_if.in_data = 8'd0;

    // reset state
    step(); step();
    check("rst_wr_en", {31'd0, a_wr_en_n}, 32'd1);
    check("rst_ready", {31'd0, a_if.in_ready}, 32'd1);
    check("rst_busy",  {31'd0, a_busy}, 32'd0);
    rst_n = 1'b1;
    armed = 1'b1;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    check("pulse_wr_en", {31'd0, a_wr_en_n}, 32'd1);
    check("pulse_ready", {31'd0, a_if.in_ready}, 32'd1);
    check("pulse_busy",  {31'd0, a_busy}, 32'd0);
    #1 rst_n = 1'b1;
    repeat (10) step();
    check("idle_no_strobe", rises, 32'd0);

    // single write, addr 2 = 0xA5
    push_a(2'd2, 8'hA5, w);
    check("sw_e0_wr_en", {31'd0, a_wr_en_n}, 32'd1);
    check("sw_e0_busy",  {31'd0, a_busy}, 32'd1);
    step();
    check("sw_e1_addr",  {30'd0, a_wr_addr}, 32'd2);
    check("sw_e1_data",  {24'd0, a_wr_data}, 32'hA5);
    check("sw_e1_wr_en", {31'd0, a_wr_en_n}, 32'd1);
    step();
    check("sw_e2_wr_en", {31'd0, a_wr_en_n}, 32'd0);
    step();
    check("sw_e3_wr_en", {31'd0, a_wr_en_n}, 32'd1);
    check("sw_e3_rf2",   {24'd0, rf[2]}, 32'hA5);
    check("sw_e3_busy",  {31'd0, a_busy}, 32'd1);
    step();
    check("sw_e4_busy",  {31'd0, a_busy}, 32'd0);
    check("sw_rises",    rises, 32'd1);

    // fill and backpressure
    base = log_n;
    push_a(2'd0, 8'h11, w);
    push_a(2'd1, 8'h22, w);
    check("bp_ready_full", {31'd0, a_if.in_ready}, 32'd0);
    push_a(2'd3, 8'h33, w);
    check("bp_third_wait", w, 32'd4);
    drain_a();
    check("bp_writes",  log_n - base, 32'd3);
    check("bp_order0",  {30'd0, log_addr[base[3:0]]}, 32'd0);
    check("bp_order1",  {30'd0, log_addr[4'(base + 1)]}, 32'd1);
    check("bp_order2",  {30'd0, log_addr[4'(base + 2)]}, 32'd3);
    check("bp_rf0",     {24'd0, rf[0]}, 32'h11);
    check("bp_rf1",     {24'd0, rf[1]}, 32'h22);
    check("bp_rf3",     {24'd0, rf[3]}, 32'h33);

    // forwarding
    push_a(2'd0, 8'h07, w);
    drain_a();
    rdl_en_n = 1'b0; rdl_addr = 2'd1;
    rdr_en_n = 1'b0; rdr_addr = 2'd0;
    push_a(2'd1, 8'h22, w);
    check("fwd_first", {24'd0, rdl_fwd}, 32'h22);
    push_a(2'd1, 8'h44, w);
    for (int k = 0; k < 40; k++) begin
      check("fwd_L_young", {24'd0, rdl_fwd}, 32'h44);
      check("fwd_R_raw",   {24'd0, rdr_fwd}, 32'h07);
      if (!a_busy) break;
      step();
    end
    check("fwd_done", {31'd0, a_busy}, 32'd0);
    rdl_en_n = 1'b1;
    push_a(2'd1, 8'h99, w);
    check("fwd_dis_pending", {24'd0, rdl_fwd}, 32'h44);
    rdl_en_n = 1'b0;
    #1;
    check("fwd_en_pending", {24'd0, rdl_fwd}, 32'h99);
    drain_a();
    check("fwd_after_drain", {24'd0, rdl_fwd}, 32'h99);
    rdl_en_n = 1'b1; rdl_addr = 2'd2;
    #1;
    check("fwd_disabled", {24'd0, rdl_fwd}, 32'hA5);
    rdr_en_n = 1'b1;

    // reset during STROBE
    push_a(2'd3, 8'h5A, w);
    push_a(2'd2, 8'h66, w);
    for (int k = 0; k < 20; k++) begin
      if (!a_wr_en_n) break;
      step();
    end
    check("mid_saw_strobe", {31'd0, a_wr_en_n}, 32'd0);
    base = rises;
    #2 rst_n = 1'b0;
    #1;
    check("mid_wr_en",  {31'd0, a_wr_en_n}, 32'd1);
    check("mid_busy",   {31'd0, a_busy}, 32'd0);
    check("mid_ready",  {31'd0, a_if.in_ready}, 32'd1);
    check("mid_rf3",    {24'd0, rf[3]}, 32'h5A);
    check("mid_edge",   rises - base, 32'd1);
    #1 rst_n = 1'b1;
    repeat (10) step();
    check("mid_no_more", rises - base, 32'd1);
    check("mid_rf2",     {24'd0, rf[2]}, 32'hA5);

    // STROBE_CYCLES = 3
    b_if.in_valid = 1'b1; b_if.in_addr = 2'd1; b_if.in_data = 8'hC3;
    step();
    b_if.in_valid = 1'b0;
    lows = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (!b_busy) break;
      check("s3_addr", {30'd0, b_wr_addr}, 32'd1);
      check("s3_data", {24'd0, b_wr_data}, 32'hC3);
      if (!b_wr_en_n) lows++;
    end
    check("s3_low_cycles", lows, 32'd3);
    check("s3_rises", b_rises, 32'd1);
    check("s3_idle", {31'd0, b_busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
